mem_port_arb: RTL and testbench

MEM_PORT_ARB -- requirements
Module: mem_port_arb

---
 rtl/mem_port_arb.sv | 105 ++++++++++
 tb/tb_mem_port_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// Arbitrates one shared memory port between an instruction-fetch port and a data port.
// Data wins by default, but an instruction request cannot be starved past MAX_DSTREAK data grants.
module mem_port_arb #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              o_fe_stall,
  output logic              o_mem_stall
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, I_DROP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  state_t     state, state_nxt;
  logic [3:0] streak, streak_nxt;
  logic       grant_i, grant_d;

  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !(i_req && streak == STREAK_MAX)) begin
          grant_d   = 1'b1;
          state_nxt = D_BUSY;
        end else if (i_req) begin
          grant_i   = 1'b1;
          state_nxt = I_BUSY;
        end
        // The streak only measures how long a waiting fetch has been passed over.
        if (!i_req || grant_i)
          streak_nxt = 4'd0;
        else if (grant_d)
          streak_nxt = streak + 4'd1;
      end
      I_BUSY: begin
        if (m_ack)
          state_nxt = IDLE;
        else if (i_flush)
          state_nxt = I_DROP;
      end
      D_BUSY, I_DROP: begin
        if (m_ack)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side request fields are captured at grant and held until the transaction retires.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state   <= IDLE;
      streak  <= 4'd0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
      m_req  <= (state_nxt != IDLE);
      if (grant_d) begin
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (grant_i) begin
        m_we   <= 1'b0;
        m_addr <= i_addr;
      end
    end
  end

  // Acks are gated by clr_n so an ack arriving during reset never leaks to a requester.
  assign i_ack       = clr_n && (state == I_BUSY) && m_ack && !i_flush;
  assign d_ack       = clr_n && (state == D_BUSY) && m_ack;
  assign i_rdata     = m_rdata;
  assign d_rdata     = m_rdata;
  assign o_fe_stall  = i_req & ~i_ack;
  assign o_mem_stall = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arb.sv
// Testbench for mem_port_arb: directed scenarios followed by randomized traffic
// checked against a transaction-level arbitration model.
module tb_mem_port_arb;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          clr_n;
  logic          i_req, i_flush, i_ack;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_ack;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_req, m_we, m_ack;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          o_fe_stall, o_mem_stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_DSTREAK(MAXS)) dut (
    .clk(clk), .clr_n(clr_n),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata),
    .o_fe_stall(o_fe_stall), .o_mem_stall(o_mem_stall)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; i_req = 1'b1; i_addr = 32'h44; d_req = 1'b0; m_ack = 1'b1;
    step(); step(); #1;
    checks++; if (m_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_req got=%h exp=0", m_req); end
    checks++; if (m_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_we got=%h exp=0", m_we); end
    checks++; if (m_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_m_addr got=%h exp=0", m_addr); end
    checks++; if (m_wdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_m_wdata got=%h exp=0", m_wdata); end
    checks++; if (i_ack !== 1'b0 || d_ack !== 1'b0) begin failures++; $display("[TB] FAIL reset_acks got=%b%b exp=00", i_ack, d_ack); end
    clr_n = 1'b1; m_ack = 1'b0;
    step(); #1;
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h44) begin failures++; $display("[TB] FAIL first_grant got=%h/%h exp=1/44", m_req, m_addr); end
    clr_n = 1'b0; m_ack = 1'b1; m_rdata = 32'h0BAD_0044; #1;
    checks++; if (i_ack !== 1'b0) begin failures++; $display("[TB] FAIL ack_in_reset got=%h exp=0", i_ack); end
    step();
    clr_n = 1'b1; i_req = 1'b0; m_ack = 1'b0; #1;
    checks++; if (m_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_abandon got=%h exp=0", m_req); end
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_addr = 32'h100; #1;
    checks++; if (o_fe_stall !== 1'b1 || m_req !== 1'b0) begin failures++; $display("[TB] FAIL fetch_pre got=%b%b exp=10", o_fe_stall, m_req); end
    step(); #1;
    checks++; if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h100) begin failures++; $display("[TB] FAIL fetch_issue got=%h/%h/%h exp=1/0/100", m_req, m_we, m_addr); end
    checks++; if (o_fe_stall !== 1'b1 || i_ack !== 1'b0) begin failures++; $display("[TB] FAIL fetch_wait got=%b%b exp=10", o_fe_stall, i_ack); end
    step(); m_ack = 1'b1; m_rdata = 32'hDEAD0001; #1;
    checks++; if (i_ack !== 1'b1 || i_rdata !== 32'hDEAD0001) begin failures++; $display("[TB] FAIL fetch_ack got=%h/%h exp=1/dead0001", i_ack, i_rdata); end
    checks++; if (o_fe_stall !== 1'b0 || m_addr !== 32'h100) begin failures++; $display("[TB] FAIL fetch_ack_hold got=%h/%h exp=0/100", o_fe_stall, m_addr); end
    step(); m_ack = 1'b0; i_req = 1'b0; #1;
    checks++; if (m_req !== 1'b0) begin failures++; $display("[TB] FAIL fetch_idle got=%h exp=0", m_req); end
  endtask

  task automatic test_priority();
    i_req = 1'b1; i_addr = 32'h180; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h55; #1;
    checks++; if (o_mem_stall !== 1'b1) begin failures++; $display("[TB] FAIL prio_stall got=%h exp=1", o_mem_stall); end
    step(); #1;
    checks++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h2000 || m_wdata !== 32'h55) begin
      failures++; $display("[TB] FAIL prio_data_first got=%h/%h/%h/%h exp=1/1/2000/55", m_req, m_we, m_addr, m_wdata); end
    m_ack = 1'b1; m_rdata = $urandom; #1;
    checks++; if (d_ack !== 1'b1 || i_ack !== 1'b0 || o_mem_stall !== 1'b0 || o_fe_stall !== 1'b1) begin
      failures++; $display("[TB] FAIL prio_d_ack got=%b%b%b%b exp=1001", d_ack, i_ack, o_mem_stall, o_fe_stall); end
    step(); m_ack = 1'b0; d_req = 1'b0; #1;
    checks++; if (m_req !== 1'b0) begin failures++; $display("[TB] FAIL prio_idle got=%h exp=0", m_req); end
    step(); #1;
    checks++; if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h180) begin failures++; $display("[TB] FAIL prio_instr_next got=%h/%h/%h exp=1/0/180", m_req, m_we, m_addr); end
    m_ack = 1'b1; m_rdata = 32'hCAFE0180; #1;
    checks++; if (i_ack !== 1'b1 || i_rdata !== 32'hCAFE0180) begin failures++; $display("[TB] FAIL prio_i_ack got=%h/%h exp=1/cafe0180", i_ack, i_rdata); end
    step(); m_ack = 1'b0; i_req = 1'b0;
  endtask

  task automatic test_streak();
    int  s;
    bit  exp_data, got_data;
    s = 0;
    i_req = 1'b1; i_addr = 32'h500; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    for (int g = 0; g < 10; g++) begin
      if (s == MAXS) begin exp_data = 1'b0; s = 0; end
      else begin exp_data = 1'b1; s++; end
      step(); #1;
      got_data = (m_addr == 32'h600);
      checks++; if (m_req !== 1'b1 || got_data != exp_data) begin
        failures++; $display("[TB] FAIL streak_grant%0d got=%h/%h exp_data=%0d", g, m_req, m_addr, exp_data); end
      m_ack = 1'b1; m_rdata = $urandom; #1;
      step(); m_ack = 1'b0;
    end
    i_req = 1'b0; d_req = 1'b0;
    step();
  endtask

  task automatic test_flush();
    i_req = 1'b1; i_addr = 32'h300;
    step(); #1;
    checks++; if (m_addr !== 32'h300) begin failures++; $display("[TB] FAIL flush_issue got=%h exp=300", m_addr); end
    i_flush = 1'b1; i_addr = 32'h340; #1;
    checks++; if (i_ack !== 1'b0) begin failures++; $display("[TB] FAIL flush_pulse got=%h exp=0", i_ack); end
    step();
    for (int k = 0; k < 3; k++) begin
      m_ack = (k == 2); i_flush = (k == 1); m_rdata = 32'h0000_0BAD; #1;
      checks++; if (i_ack !== 1'b0 || m_req !== 1'b1 || m_addr !== 32'h300 || o_fe_stall !== 1'b1) begin
        failures++; $display("[TB] FAIL flush_drop%0d got=%h/%h/%h/%h exp=0/1/300/1", k, i_ack, m_req, m_addr, o_fe_stall); end
      step();
    end
    m_ack = 1'b0; i_flush = 1'b0; #1;
    checks++; if (m_req !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle got=%h exp=0", m_req); end
    step(); #1;
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h340 || m_we !== 1'b0) begin failures++; $display("[TB] FAIL flush_target got=%h/%h/%h exp=1/340/0", m_req, m_addr, m_we); end
    m_ack = 1'b1; m_rdata = 32'h1234_0340; #1;
    checks++; if (i_ack !== 1'b1 || i_rdata !== 32'h1234_0340) begin failures++; $display("[TB] FAIL flush_target_ack got=%h/%h exp=1/12340340", i_ack, i_rdata); end
    step(); m_ack = 1'b0; i_req = 1'b0;
  endtask

  task automatic test_flush_ack();
    i_req = 1'b1; i_addr = 32'h400;
    step(); m_ack = 1'b1; i_flush = 1'b1; m_rdata = 32'h0000_0400; #1;
    checks++; if (i_ack !== 1'b0) begin failures++; $display("[TB] FAIL flushack_suppress got=%h exp=0", i_ack); end
    step(); m_ack = 1'b0; i_addr = 32'h440; #1;
    checks++; if (m_req !== 1'b0) begin failures++; $display("[TB] FAIL flushack_idle got=%h exp=0", m_req); end
    step(); i_flush = 1'b0; #1;
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h440) begin failures++; $display("[TB] FAIL flushack_regrant got=%h/%h exp=1/440", m_req, m_addr); end
    m_ack = 1'b1; m_rdata = 32'h5A5A_0440; #1;
    checks++; if (i_ack !== 1'b1 || i_rdata !== 32'h5A5A_0440) begin failures++; $display("[TB] FAIL flushack_ack got=%h/%h exp=1/5a5a0440", i_ack, i_rdata); end
    step(); m_ack = 1'b0; i_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_wdata = 32'h0;
    step(); #1;
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h3000) begin failures++; $display("[TB] FAIL rmid_issue got=%h/%h exp=1/3000", m_req, m_addr); end
    clr_n = 1'b0; #1;
    checks++; if (d_ack !== 1'b0) begin failures++; $display("[TB] FAIL rmid_in_reset got=%h exp=0", d_ack); end
    step();
    clr_n = 1'b1; m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF; #1;
    checks++; if (m_req !== 1'b0 || m_addr !== 32'h0 || d_ack !== 1'b0 || o_mem_stall !== 1'b1) begin
      failures++; $display("[TB] FAIL rmid_late_ack got=%h/%h/%h/%h exp=0/0/0/1", m_req, m_addr, d_ack, o_mem_stall); end
    step(); m_ack = 1'b0; #1;
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h3000 || m_we !== 1'b0) begin failures++; $display("[TB] FAIL rmid_regrant got=%h/%h/%h exp=1/3000/0", m_req, m_addr, m_we); end
    m_ack = 1'b1; m_rdata = 32'h7777_3000; #1;
    checks++; if (d_ack !== 1'b1 || d_rdata !== 32'h7777_3000) begin failures++; $display("[TB] FAIL rmid_ack got=%h/%h exp=1/77773000", d_ack, d_rdata); end
    step(); m_ack = 1'b0; d_req = 1'b0;
  endtask

  // Transaction-level model: pending requests, one outstanding transfer, and a count of
  // data grants that overtook a waiting fetch.
  task automatic test_random();
    bit          i_pend, d_pend, dwe, busy, ex_we, ack_now, is_instr, give_i, give_d;
    logic [31:0] ia, da, dw, ex_addr, ex_wdata;
    int          lat, cnt, streak_m;
    bit          exp_i_ack, exp_d_ack;
    i_pend = 0; d_pend = 0; busy = 0; streak_m = 0; lat = 0; cnt = 0;
    is_instr = 0; ex_we = 0; ex_addr = 0; ex_wdata = 0; ia = 0; da = 0; dw = 0; dwe = 0;
    clr_n = 1'b0; i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0; i_flush = 1'b0;
    step();
    clr_n = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!i_pend && $urandom_range(0, 2) != 0) begin i_pend = 1; ia = $urandom; end
      if (!d_pend && $urandom_range(0, 2) != 0) begin d_pend = 1; da = $urandom; dw = $urandom; dwe = 1'($urandom_range(0, 1)); end
      i_req = i_pend; i_addr = ia; d_req = d_pend; d_addr = da; d_wdata = dw; d_we = dwe;
      m_rdata = $urandom;
      ack_now = busy && (cnt == lat);
      m_ack = busy ? ack_now : ($urandom_range(0, 3) == 0);
      #1;
      exp_i_ack = ack_now && is_instr;
      exp_d_ack = ack_now && !is_instr;
      checks++; if (i_ack !== exp_i_ack || d_ack !== exp_d_ack) begin
        failures++; $display("[TB] FAIL rnd_acks cyc=%0d got=%b%b exp=%b%b", cyc, i_ack, d_ack, exp_i_ack, exp_d_ack); end
      checks++; if ((exp_i_ack && i_rdata !== m_rdata) || (exp_d_ack && !ex_we && d_rdata !== m_rdata)) begin
        failures++; $display("[TB] FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h", cyc, i_rdata, d_rdata, m_rdata); end
      checks++; if (m_req !== busy) begin failures++; $display("[TB] FAIL rnd_m_req cyc=%0d got=%h exp=%h", cyc, m_req, busy); end
      if (busy) begin
        checks++; if (m_addr !== ex_addr || m_we !== ex_we || (ex_we && m_wdata !== ex_wdata)) begin
          failures++; $display("[TB] FAIL rnd_fields cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, m_addr, m_we, m_wdata, ex_addr, ex_we, ex_wdata); end
      end
      checks++; if (o_fe_stall !== (i_pend && !exp_i_ack) || o_mem_stall !== (d_pend && !exp_d_ack)) begin
        failures++; $display("[TB] FAIL rnd_stalls cyc=%0d got=%b%b exp=%b%b", cyc, o_fe_stall, o_mem_stall, i_pend && !exp_i_ack, d_pend && !exp_d_ack); end
      if (busy) begin
        if (ack_now) begin
          busy = 0;
          if (is_instr) i_pend = 0; else d_pend = 0;
        end else cnt++;
      end else begin
        give_i = i_pend && (!d_pend || streak_m == MAXS);
        give_d = d_pend && !give_i;
        if (give_d) begin
          busy = 1; is_instr = 0; ex_addr = da; ex_we = dwe; ex_wdata = dw;
          streak_m = i_pend ? streak_m + 1 : 0;
        end else if (give_i) begin
          busy = 1; is_instr = 1; ex_addr = ia; ex_we = 0;
          streak_m = 0;
        end else streak_m = 0;
        lat = $urandom_range(0, 2); cnt = 0;
      end
      step();
    end
    i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clr_n = 1'b0; i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    m_ack = 1'b0; m_rdata = '0;
    step();
    test_reset();
    test_fetch();
    test_priority();
    test_streak();
    test_flush();
    test_flush_ack();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
